// File: rtl/accel_output_writer.sv
// Output write-back buffer: captures psum words from the control unit and
// drains them to memory as single-beat AXI4-Lite writes on a flush command.
module accel_output_writer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 25
) (
    input  logic                      CLK,
    input  logic                      RESETN,
    input  logic                      out_storage_wr_en,
    input  logic [DATA_WIDTH-1:0]     psum_in,
    input  logic [ADDR_WIDTH-1:0]     output_base_addr,
    input  logic                      flush,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(DEPTH+1)-1:0] word_count,
    output logic                      drop_err,
    output logic                      slv_err,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  drop_q, drop_d;
    logic                  slv_q, slv_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  capture_c;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Next-state, capture and AXI channel control.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        base_d    = base_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        drop_d    = drop_q;
        slv_d     = slv_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        capture_c = 1'b0;

        // Captures are only accepted while idle.
        if (out_storage_wr_en && (state_q != IDLE)) begin
            drop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (out_storage_wr_en) begin
                    if (wr_ptr_q < CW'(DEPTH)) begin
                        capture_c = 1'b1;
                        wr_ptr_d  = wr_ptr_q + CW'(1);
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                // Same-cycle capture counts toward the drain, hence wr_ptr_d.
                if (flush) begin
                    if (wr_ptr_d == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = SEND;
                        base_d    = output_base_addr;
                        rd_ptr_d  = '0;
                        busy_d    = 1'b1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = output_base_addr;
                        wdata_d   = (capture_c && (wr_ptr_q == '0)) ? psum_in : mem[0];
                    end
                end
            end
            SEND: begin
                if (awvalid_q && m_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_wready) begin
                    wvalid_d = 1'b0;
                end
                if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
                    state_d  = RESP;
                    bready_d = 1'b1;
                end
            end
            RESP: begin
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    if (m_bresp != 2'b00) begin
                        slv_d = 1'b1;
                    end
                    rd_ptr_d = rd_ptr_q + CW'(1);
                    if (rd_ptr_d == wr_ptr_q) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = SEND;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = base_q + (ADDR_WIDTH'(rd_ptr_d) << 2);
                        wdata_d   = mem[rd_ptr_d];
                    end
                end
            end
            FIN: begin
                busy_d   = 1'b0;
                wr_ptr_d = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            base_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
            slv_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            base_q    <= base_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
            slv_q     <= slv_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Word buffer; contents need no reset.
    always_ff @(posedge CLK) begin
        if (RESETN && capture_c) begin
            mem[wr_ptr_q] <= psum_in;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = wr_ptr_q;
    assign drop_err   = drop_q;
    assign slv_err    = slv_q;
    assign m_awaddr   = awaddr_q;
    assign m_awvalid  = awvalid_q;
    assign m_wdata    = wdata_q;
    assign m_wstrb    = '1;
    assign m_wvalid   = wvalid_q;
    assign m_bready   = bready_q;

endmodule

// File: tb/tb_accel_output_writer.sv
// Directed bench for accel_output_writer: capture, drain, backpressure,
// overflow, error responses, address wrap and reset mid-drain.
module tb_accel_output_writer;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        out_storage_wr_en;
    logic [31:0] psum_in;
    logic [31:0] output_base_addr;
    logic        flush;
    logic        busy;
    logic        done;
    logic [4:0]  word_count;
    logic        drop_err;
    logic        slv_err;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    int tests = 0;
    int fails = 0;

    accel_output_writer dut (
        .CLK               (CLK),
        .RESETN            (RESETN),
        .out_storage_wr_en (out_storage_wr_en),
        .psum_in           (psum_in),
        .output_base_addr  (output_base_addr),
        .flush             (flush),
        .busy              (busy),
        .done              (done),
        .word_count        (word_count),
        .drop_err          (drop_err),
        .slv_err           (slv_err),
        .m_awaddr          (m_awaddr),
        .m_awvalid         (m_awvalid),
        .m_awready         (m_awready),
        .m_wdata           (m_wdata),
        .m_wstrb           (m_wstrb),
        .m_wvalid          (m_wvalid),
        .m_wready          (m_wready),
        .m_bresp           (m_bresp),
        .m_bvalid          (m_bvalid),
        .m_bready          (m_bready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic capture(input int n, input logic [31:0] d0);
        for (int i = 0; i < n; i++) begin
            out_storage_wr_en = 1'b1;
            psum_in = d0 + 32'(i);
            @(negedge CLK);
        end
        out_storage_wr_en = 1'b0;
    endtask

    // Flush and act as slave for n words; words are d0+i at base+4*i.
    task automatic drain(input int n, input logic [31:0] base, input logic [31:0] d0,
                         input int aw_delay, input int bad_idx, input bit cap_last,
                         input bit poke);
        int cyc;
        out_storage_wr_en = cap_last;
        psum_in = d0 + 32'(n - 1);
        flush = 1'b1;
        output_base_addr = base;
        m_awready = 1'b0;
        m_wready = 1'b0;
        @(negedge CLK);
        flush = 1'b0;
        out_storage_wr_en = 1'b0;
        cyc = 1;
        chk("wcount_in_drain", 32'(word_count), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk("awvalid_up", 32'(m_awvalid), 32'd1);
            chk("wvalid_up", 32'(m_wvalid), 32'd1);
            chk("awaddr", m_awaddr, base + 32'(4 * i));
            chk("wdata", m_wdata, d0 + 32'(i));
            chk("busy_send", 32'(busy), 32'd1);
            chk("done_low", 32'(done), 32'd0);
            if (poke && i == 0) begin
                out_storage_wr_en = 1'b1;
                psum_in = 32'hDEAD_BEEF;
            end
            for (int k = 0; k < aw_delay; k++) begin
                m_awready = 1'b0;
                m_wready = 1'b1;
                @(negedge CLK);
                out_storage_wr_en = 1'b0;
                cyc++;
                chk("awvalid_hold", 32'(m_awvalid), 32'd1);
                chk("wvalid_drop", 32'(m_wvalid), 32'd0);
                chk("awaddr_hold", m_awaddr, base + 32'(4 * i));
            end
            m_awready = 1'b1;
            m_wready = 1'b1;
            @(negedge CLK);
            out_storage_wr_en = 1'b0;
            cyc++;
            chk("bready_up", 32'(m_bready), 32'd1);
            chk("awvalid_done", 32'(m_awvalid), 32'd0);
            chk("wvalid_done", 32'(m_wvalid), 32'd0);
            m_awready = 1'b0;
            m_wready = 1'b0;
            m_bvalid = 1'b1;
            m_bresp = (i == bad_idx) ? 2'b10 : 2'b00;
            @(negedge CLK);
            m_bvalid = 1'b0;
            m_bresp = 2'b00;
            cyc++;
            chk("bready_down", 32'(m_bready), 32'd0);
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_fin", 32'(busy), 32'd1);
        $display("[TB] drain of %0d words: done %0d cycles after flush", n, cyc);
        @(negedge CLK);
        chk("done_once", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("wcount_after", 32'(word_count), 32'd0);
    endtask

    task automatic check_reset_state();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wcount", 32'(word_count), 32'd0);
        chk("rst_drop", 32'(drop_err), 32'd0);
        chk("rst_slv", 32'(slv_err), 32'd0);
        chk("rst_awvalid", 32'(m_awvalid), 32'd0);
        chk("rst_wvalid", 32'(m_wvalid), 32'd0);
        chk("rst_bready", 32'(m_bready), 32'd0);
        chk("rst_awaddr", m_awaddr, 32'd0);
        chk("rst_wdata", m_wdata, 32'd0);
    endtask

    initial begin
        RESETN = 1'b0;
        out_storage_wr_en = 1'b0;
        psum_in = '0;
        output_base_addr = '0;
        flush = 1'b0;
        m_awready = 1'b0;
        m_wready = 1'b0;
        m_bresp = 2'b00;
        m_bvalid = 1'b0;

        // Reset state.
        repeat (2) @(negedge CLK);
        check_reset_state();
        chk("wstrb", 32'(m_wstrb), 32'hF);
        RESETN = 1'b1;
        @(negedge CLK);

        // Full tile, zero-wait slave: done 51 cycles after flush.
        capture(25, 32'h100);
        chk("wcount_25", 32'(word_count), 32'd25);
        drain(25, 32'h4000_0000, 32'h100, 0, -1, 1'b0, 1'b0);
        chk("drop_clean", 32'(drop_err), 32'd0);
        chk("slv_clean", 32'(slv_err), 32'd0);

        // AW backpressure of 3 cycles with W immediate.
        capture(3, 32'h200);
        drain(3, 32'h0000_1000, 32'h200, 3, -1, 1'b0, 1'b0);
        chk("drop_clean2", 32'(drop_err), 32'd0);

        // Empty flush: done next cycle, no busy, no traffic.
        flush = 1'b1;
        output_base_addr = 32'h1234_5678;
        @(negedge CLK);
        flush = 1'b0;
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_awvalid", 32'(m_awvalid), 32'd0);
        @(negedge CLK);
        chk("empty_done_off", 32'(done), 32'd0);
        chk("empty_busy_off", 32'(busy), 32'd0);
        chk("empty_awvalid2", 32'(m_awvalid), 32'd0);

        // Capture in the flush cycle is drained; capture while busy is dropped.
        capture(1, 32'h600);
        drain(2, 32'h0000_2000, 32'h600, 0, -1, 1'b1, 1'b1);
        chk("drop_busy", 32'(drop_err), 32'd1);

        // Error response on second write, address wrap past 2^32.
        capture(4, 32'h500);
        drain(4, 32'hFFFF_FFF8, 32'h500, 0, 1, 1'b0, 1'b0);
        chk("slv_sticky", 32'(slv_err), 32'd1);

        // Reset clears sticky flags; then overflow by one word.
        RESETN = 1'b0;
        @(negedge CLK);
        chk("sticky_drop_clr", 32'(drop_err), 32'd0);
        chk("sticky_slv_clr", 32'(slv_err), 32'd0);
        RESETN = 1'b1;
        capture(26, 32'h300);
        chk("wcount_full", 32'(word_count), 32'd25);
        chk("drop_overflow", 32'(drop_err), 32'd1);
        drain(25, 32'h8000_0000, 32'h300, 0, -1, 1'b0, 1'b0);

        // Reset while in RESP with bvalid pending; late bvalid ignored.
        RESETN = 1'b0;
        @(negedge CLK);
        RESETN = 1'b1;
        capture(2, 32'h700);
        flush = 1'b1;
        output_base_addr = 32'h0000_3000;
        @(negedge CLK);
        flush = 1'b0;
        m_awready = 1'b1;
        m_wready = 1'b1;
        @(negedge CLK);
        m_awready = 1'b0;
        m_wready = 1'b0;
        chk("mid_bready", 32'(m_bready), 32'd1);
        RESETN = 1'b0;
        m_bvalid = 1'b1;
        m_bresp = 2'b10;
        @(negedge CLK);
        check_reset_state();
        RESETN = 1'b1;
        @(negedge CLK);
        chk("late_b_bready", 32'(m_bready), 32'd0);
        chk("late_b_awvalid", 32'(m_awvalid), 32'd0);
        chk("late_b_slv", 32'(slv_err), 32'd0);
        chk("late_b_busy", 32'(busy), 32'd0);
        chk("late_b_done", 32'(done), 32'd0);
        m_bvalid = 1'b0;
        m_bresp = 2'b00;
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
